vga_window_timing: RTL
======================

# vga_window_timing

Parametrised VGA timing and image-window generator, successor to the fixed 800x600 timing block. It produces HSYNC, VSYNC and DE from configurable porch and sync widths, and places a stored image of configurable size, offset and integer zoom inside the active area. It issues frame-buffer read addresses and compensates a configurable RAM read latency, so DATA_OUT, DE and the syncs leave the block cycle-aligned. It sits between the frame-buffer RAM and the DAC/connector pins.

## Interface
- H_SYNC, 128: HSYNC pulse width, pixels
- H_BACK, 88: horizontal back porch
- H_ACTIVE, 800: visible pixels per line
- H_FRONT, 40: horizontal front porch
- V_SYNC, 4: VSYNC pulse width, lines
- V_BACK, 23: vertical back porch
- V_ACTIVE, 600: visible lines
- V_FRONT, 1: vertical front porch
- SYNC_POL, 0: 0 = sync pulses active-low, 1 = active-high
- IMG_W, 128: image width, source pixels
- IMG_H, 96: image height, source lines
- IMG_X, 0: image left offset within the active area
- IMG_Y, 0: image top offset within the active area
- SCALE_SHIFT, 0: each source pixel is replicated 2^SCALE_SHIFT times horizontally and vertically
- DATA_W, 8: pixel width
- ADDR_W, 16: address width
- RD_LAT, 1: RAM read latency in cycles (1..4)
- BORDER, 0: DATA_OUT value inside the active area but outside the image

Ports:
- CLK_40M  in  1  pixel clock
- RST_N  in  1  synchronous, active-low reset
- DATA_IN  in  DATA_W  RAM read data
- TEST_MODE  in  1  selects the colour-bar pattern (effective only with the macro)
- ADDRESS  out  ADDR_W  RAM read address
- ADDR_VALID  out  1  ADDRESS is inside the image
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  active-video enable
- DATA_OUT  out  DATA_W  pixel output
- FRAME_START  out  1  one-cycle pulse, aligned to outputs, for counter state (0,0)

## Operation
- Counters:
  - h counts 0..H_TOT-1, where H_TOT = sum of the four H parameters.
  - v increments when h wraps, and counts 0..V_TOT-1.
- Sync and active decode:
  - Sync is active while h<H_SYNC (horizontal) and while v<V_SYNC (vertical).
  - Active region: h in [H_SYNC+H_BACK, +H_ACTIVE), and v in [V_SYNC+V_BACK, +V_ACTIVE).
- Image window:
  - ax = h-H_SYNC-H_BACK-IMG_X; ay likewise for v.
  - in_img = active && 0<=ax<(IMG_W<<SCALE_SHIFT) && 0<=ay<(IMG_H<<SCALE_SHIFT).
  - ix = ax>>SCALE_SHIFT, iy = ay>>SCALE_SHIFT.
  - ADDRESS = (iy*IMG_W + ix) mod 2^ADDR_W. It may be built incrementally (row base plus column counter); no multiplier is required, but the result must be identical.
  - When in_img=0, ADDRESS=0 and ADDR_VALID=0.
- Output select, per output pixel:
  - not active: DATA_OUT = 0
  - active and not in_img: DATA_OUT = BORDER
  - in_img: DATA_OUT = DATA_IN
- Reset (RST_N low at a rising edge) sets:
  - counters to (0,0) and every pipeline stage flushed
  - HSYNC and VSYNC to their inactive level (~SYNC_POL)
  - DE=0, ADDR_VALID=0, ADDRESS=0, DATA_OUT=0, FRAME_START=0
- Reset asserted mid-frame takes effect on the next edge. The first cycle after release restarts at (0,0) with no partial line.

## Timing
- The counter state at cycle t is (h,v).
- ADDRESS and ADDR_VALID are registered and appear at t+1.
- DATA_IN is sampled at t+1+RD_LAT. The RAM must return data for ADDRESS RD_LAT cycles after ADDRESS is presented.
- HSYNC, VSYNC, DE, DATA_OUT and FRAME_START are registered and appear at t+L, where L = RD_LAT+2. All five are mutually aligned.
- The HSYNC period is exactly H_TOT cycles. The VSYNC period is exactly H_TOT*V_TOT cycles.
- Before the pipeline fills after reset, the outputs hold their reset values.
- An image extending past the active area is clipped: in_img is gated by active.
- ADDRESS wraps modulo 2^ADDR_W with no error indication.

## Configuration
- VGA_TEST_PATTERN_EN defined, TEST_MODE=1:
  - DATA_OUT in the active area shows 8 vertical colour bars in RGB332 (DATA_W must be 8; any other value is an elaboration error).
  - Bar width is H_ACTIVE>>3; the last bar absorbs the remainder.
  - Bar colours, in order: FF, FC, 1F, 1C, E3, E0, 03, 00.
  - DATA_IN is ignored. ADDRESS and ADDR_VALID behave unchanged. Latency is unchanged.
- Macro not defined: TEST_MODE is ignored and no pattern logic is built.

## Test plan
- Defaults, reset released at cycle 0 → first HSYNC low at cycle 3, lasting 128 cycles; HSYNC period 1056; VSYNC low for 4*1056 cycles; frame of 663168 cycles; FRAME_START once per frame.
- Defaults, RAM model with data = ADDRESS[7:0] → (h=216,v=27) gives ADDRESS=0 one cycle later and DATA_OUT=00 with DE=1 at L=3; (343,122) gives ADDRESS=12287 and DATA_OUT=FF; (344,27) gives ADDR_VALID=0 and DATA_OUT=BORDER.
- SCALE_SHIFT=1, IMG_X=10 → h=226 and 227 both give ADDRESS=0; h=228 gives 1; line v=28 repeats line 27's addresses.
- RD_LAT=4, SYNC_POL=1 → L=6; DE aligned to the DATA_OUT edge; HSYNC is high during the pulse; ADDRESS still leads DATA_OUT by 5 cycles.
- RST_N pulsed low for 1 cycle mid-line (h=500) → the next edge shows all outputs at reset values; counting resumes from (0,0); the first HSYNC pulse is a full 128 cycles.
- Macro defined, TEST_MODE=1 → DATA_OUT=FF for the first 100 active pixels, then FC, and 00 for the final 100 pixels.

Source files
------------

// File: rtl/vga_window_timing.sv
// VGA sync/DE generator with a scaled, offset image window and RAM read-latency alignment.
// Defining VGA_TEST_PATTERN_EN adds an 8-bar RGB332 colour pattern selected by TEST_MODE.

module vga_window_timing #(
    parameter int H_SYNC      = 128,
    parameter int H_BACK      = 88,
    parameter int H_ACTIVE    = 800,
    parameter int H_FRONT     = 40,
    parameter int V_SYNC      = 4,
    parameter int V_BACK      = 23,
    parameter int V_ACTIVE    = 600,
    parameter int V_FRONT     = 1,
    parameter bit SYNC_POL    = 1'b0,
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 96,
    parameter int IMG_X       = 0,
    parameter int IMG_Y       = 0,
    parameter int SCALE_SHIFT = 0,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int RD_LAT      = 1,
    parameter logic [DATA_W-1:0] BORDER = '0
) (
    input  logic              CLK_40M,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              TEST_MODE,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              ADDR_VALID,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DE,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              FRAME_START
);

    localparam int H_TOT  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOT  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW = $clog2(H_TOT);
    localparam int unsigned VW = $clog2(V_TOT);
    localparam int H_ACT0 = H_SYNC + H_BACK;
    localparam int V_ACT0 = V_SYNC + V_BACK;
    localparam int IMG_WS = IMG_W << SCALE_SHIFT;
    localparam int IMG_HS = IMG_H << SCALE_SHIFT;

    typedef struct packed {
        logic fs;
        logic hs;
        logic vs;
        logic de;
        logic img;
    } ctrl_t;

    if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
        $error("vga_window_timing: RD_LAT must be in 1..4");
    end

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    int                hx, vy, ax, ay;
    ctrl_t             ctrl_c;
    logic [ADDR_W-1:0] addr_c;
    ctrl_t             ctrl_q [RD_LAT+1];
    ctrl_t             ctrl_o;
    logic [DATA_W-1:0] data_c;

    // Raster counters
    always_ff @(posedge CLK_40M) begin
        if (!RST_N) begin
            h <= '0;
            v <= '0;
        end else if (h == HW'(H_TOT - 1)) begin
            h <= '0;
            v <= (v == VW'(V_TOT - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Sync, active and image-window decode of the current counter state
    always_comb begin
        hx = int'(h) - H_ACT0;
        vy = int'(v) - V_ACT0;
        ax = hx - IMG_X;
        ay = vy - IMG_Y;
        ctrl_c     = '0;
        ctrl_c.fs  = (h == '0) && (v == '0);
        ctrl_c.hs  = int'(h) < H_SYNC;
        ctrl_c.vs  = int'(v) < V_SYNC;
        ctrl_c.de  = (hx >= 0) && (hx < H_ACTIVE) && (vy >= 0) && (vy < V_ACTIVE);
        ctrl_c.img = ctrl_c.de && (ax >= 0) && (ax < IMG_WS) && (ay >= 0) && (ay < IMG_HS);
        addr_c     = ADDR_W'((ay >>> SCALE_SHIFT) * IMG_W + (ax >>> SCALE_SHIFT));
    end

    // Address issue plus control delay line matching the RAM latency
    always_ff @(posedge CLK_40M) begin
        if (!RST_N) begin
            ADDRESS    <= '0;
            ADDR_VALID <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) ctrl_q[i] <= '0;
        end else begin
            ADDRESS    <= ctrl_c.img ? addr_c : '0;
            ADDR_VALID <= ctrl_c.img;
            ctrl_q[0]  <= ctrl_c;
            for (int i = 1; i <= RD_LAT; i++) ctrl_q[i] <= ctrl_q[i-1];
        end
    end

    assign ctrl_o = ctrl_q[RD_LAT];

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE >> 3;
    localparam logic [7:0] BAR_COL [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C,
                                           8'hE3, 8'hE0, 8'h03, 8'h00};

    if (DATA_W != 8) begin : g_bad_data_w
        $error("vga_window_timing: test pattern requires DATA_W == 8");
    end

    logic [2:0] bar_c;
    logic [2:0] bar_q [RD_LAT+1];

    // Last bar absorbs the remainder of the active width
    always_comb begin
        bar_c = '0;
        for (int k = 1; k < 8; k++) begin
            if (hx >= k * BAR_W) bar_c = 3'(k);
        end
    end

    always_ff @(posedge CLK_40M) begin
        if (!RST_N) begin
            for (int i = 0; i <= RD_LAT; i++) bar_q[i] <= '0;
        end else begin
            bar_q[0] <= bar_c;
            for (int i = 1; i <= RD_LAT; i++) bar_q[i] <= bar_q[i-1];
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = TEST_MODE;
`endif

    // Pixel source select
    always_comb begin
        data_c = '0;
        if (ctrl_o.de) begin
            data_c = ctrl_o.img ? DATA_IN : BORDER;
`ifdef VGA_TEST_PATTERN_EN
            if (TEST_MODE) data_c = DATA_W'(BAR_COL[bar_q[RD_LAT]]);
`endif
        end
    end

    always_ff @(posedge CLK_40M) begin
        if (!RST_N) begin
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
            DE          <= 1'b0;
            DATA_OUT    <= '0;
            FRAME_START <= 1'b0;
        end else begin
            HSYNC       <= ctrl_o.hs ? SYNC_POL : ~SYNC_POL;
            VSYNC       <= ctrl_o.vs ? SYNC_POL : ~SYNC_POL;
            DE          <= ctrl_o.de;
            DATA_OUT    <= data_c;
            FRAME_START <= ctrl_o.fs;
        end
    end

endmodule
